mac_datapath: RTL and testbench
===============================

# mac_datapath

Datapath responder for the dot-product controller. It consumes the controller's operand and command strobes (`write_x`, `write_w`, `acc_write`, `res_write`, `clear_acc`, `done`) and performs the multiply-accumulate for each output. It stores Q scaled results in a result bank that downstream logic reads back with one-cycle latency. It sits between the controller and the result consumer and holds no sequencing of its own beyond its pointers and flags.

## Interface
- `N`, default 8: operand and result width (signed two's complement).
- `d`, default 4: terms per dot product.
- `Q`, default 3: results per run (result bank depth).
- `F`, default 0: fractional right-shift applied to the accumulator before storing.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `rst_dp` input, 1 bit: synchronous soft clear from the controller. Same effect as `rst`, except the result bank contents are kept.
- `write_x` input, 1 bit: load `x` into the operand register.
- `write_w` input, 1 bit: load `weight` into the weight register.
- `x` input, N bits: signed input sample.
- `weight` input, N bits: signed weight.
- `acc_write` input, 1 bit: add the product of the operand and weight registers to the accumulator.
- `res_write` input, 1 bit: scale and store the accumulator at `q_ptr`, then advance `q_ptr`.
- `clear_acc` input, 1 bit: zero the accumulator and the term counter.
- `done` input, 1 bit: end of run.
- `rd_addr` input, clog2(Q) bits: result read address.
- `rd_data` output, N bits: registered read data.
- `res_valid` output, 1 bit: one-cycle pulse after each result store.
- `res_idx` output, clog2(Q) bits: index of the result just stored; valid while `res_valid` is high.
- `run_done` output, 1 bit: sticky; set by `done`.
- `proto_err` output, 1 bit: sticky protocol-violation flag.
- `ovf` output, 1 bit: sticky saturation flag. Present only with `MAC_SAT_EN`; otherwise tied 0.

## Operation
- Accumulator width is A = 2N + clog2(d) + 1, signed. Products are full-width signed (2N bits), sign-extended to A.
- Operand and weight registers:
  - A write strobe loads the register and sets that register's valid flag.
  - `acc_write` consumes both valid flags, clearing them.
- `acc_write` with either valid flag clear:
  - Sets `proto_err`.
  - Still accumulates the stale register values.
- Term counter increments on each `acc_write`. An `acc_write` when the counter already equals d sets `proto_err` and still accumulates.
- `res_write` stores `sat_or_wrap(acc >>> F)` at `q_ptr`:
  - `q_ptr` then increments, wrapping from Q-1 to 0.
  - `res_valid` and `res_idx` are registered outputs, asserted the cycle after the store.
- `clear_acc`: the accumulator and term counter become 0 and both valid flags clear.
- `done`: sets `run_done`. It remains set until `rst` or `rst_dp`.
- Same-cycle priorities, evaluated on the pre-edge accumulator value:
  - `res_write` together with `acc_write`: the stored result excludes this cycle's product; the product is still added.
  - `clear_acc` together with `acc_write`: the accumulator becomes exactly the new product and the term counter becomes 1.
  - `res_write` together with `clear_acc`: the pre-clear accumulator is stored.
  - `write_x` together with `acc_write`: the product uses the old register value; the new value loads and its valid flag is set.
- Reset values, after `rst` or `rst_dp`:
  - Accumulator, operand/weight registers, valid flags, term counter and `q_ptr` are 0.
  - `res_valid`, `run_done`, `proto_err` and `ovf` are 0.
  - `rd_data` is 0.
  - The result bank is zeroed by `rst` only.
- Reset mid-accumulation discards the partial sum. No result is written.

## Timing
- Strobe to register update: 1 cycle. The value is visible on the register output the cycle after the strobe.
- `res_write` samples the accumulator register. It therefore includes every `acc_write` from strictly earlier cycles.
- `res_valid` follows `res_write` by 1 cycle.
- Read path: `rd_data` follows `rd_addr` by 1 cycle.
  - A read of the address being written in the same cycle returns the old contents.
- There is no back-pressure. Every strobe is accepted in the cycle it is asserted.

## Configuration
- `MAC_SAT_EN` defined:
  - The stored result saturates to [-2^(N-1), 2^(N-1)-1].
  - Any clamp sets `ovf`.
- `MAC_SAT_EN` undefined:
  - The stored result is the low N bits of `acc >>> F` (wraps).
  - `ovf` is constant 0 and no saturation logic is built.

## Structure
- Shared package holds:
  - Accumulator-width and pointer-width functions: A, clog2(Q), clog2(d+1).
  - The saturation/scaling function.
  - The protocol-error cause enum: `ERR_NO_X`, `ERR_NO_W`, `ERR_TERM_OVR`.
- One sub-module, `mac_result_bank`:
  - Q x N registers.
  - Synchronous write port with registered read port.
  - `rst`-only clear.

## Test plan
- N=8, d=4, F=0. Load x={1,2,3,4} and w={5,6,7,8}, each pair followed by `acc_write`, then `res_write` -> bank[0]=70, `res_valid` pulse with `res_idx`=0.
- Three full dot products with `clear_acc` between them, then a fourth -> results at idx 0, 1, 2; the fourth overwrites idx 0 (wrap).
- x=-128, w=-128 for one term (bank result 16384):
  - With `MAC_SAT_EN` -> 127, `ovf`=1.
  - Without it -> 0.
  - x=127, w=127 without the macro -> 1.
- `acc_write` with no preceding `write_w` -> `proto_err`=1. A fifth `acc_write` with d=4 -> `proto_err`=1 and the accumulator still updates.
- `clear_acc` and `acc_write` in the same cycle with x=3, w=-2 -> accumulator = -6 and term counter = 1. `res_write` with `acc_write` stores the pre-add value.
- `rst_dp` asserted after 2 terms -> accumulator, flags and `q_ptr` are 0 and the bank is preserved (read of idx 0 returns the prior 70). `done` -> `run_done` stays 1 until `rst`.

Source files
------------

// File: rtl/mac_datapath_pkg.sv
// -----------------------------------------------------------------------------
// mac_datapath_pkg
// Shared types and helper functions for the MAC datapath slice.
//   accWidth(n, d)   : accumulator width, 2n + clog2(d) + 1
//   ptrWidth(q)      : result-bank pointer / address width, clog2(q) (min 1)
//   termWidth(d)     : term counter width, clog2(d + 1)
//   scaleSat         : arithmetic right shift then clamp to a signed n-bit range
//   scaleClamps      : reports whether scaleSat had to clamp
//   errCause         : classifies an acc_write against the operand/term state
// Used by mac_datapath (MAC_SAT_EN selects the saturating store path).
// -----------------------------------------------------------------------------
package mac_datapath_pkg;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_NO_X,
        ERR_NO_W,
        ERR_TERM_OVR
    } err_cause_e;

    function automatic int accWidth(input int n, input int d);
        return 2 * n + $clog2(d) + 1;
    endfunction

    function automatic int ptrWidth(input int q);
        return (q > 1) ? $clog2(q) : 1;
    endfunction

    function automatic int termWidth(input int d);
        return (d > 0) ? $clog2(d + 1) : 1;
    endfunction

    // The accumulator is sign-extended to 64 bits by the caller so this one
    // function serves every parameterisation.
    function automatic logic signed [63:0] scaleSat(input logic signed [63:0] acc,
                                                    input int n, input int f);
        logic signed [63:0] shifted;
        logic signed [63:0] maxV;
        logic signed [63:0] minV;
        shifted = acc >>> f;
        maxV    = (64'sd1 <<< (n - 1)) - 64'sd1;
        minV    = -(64'sd1 <<< (n - 1));
        if (shifted > maxV) begin
            return maxV;
        end else if (shifted < minV) begin
            return minV;
        end
        return shifted;
    endfunction

    function automatic logic scaleClamps(input logic signed [63:0] acc,
                                         input int n, input int f);
        logic signed [63:0] shifted;
        logic signed [63:0] maxV;
        logic signed [63:0] minV;
        shifted = acc >>> f;
        maxV    = (64'sd1 <<< (n - 1)) - 64'sd1;
        minV    = -(64'sd1 <<< (n - 1));
        return (shifted > maxV) || (shifted < minV);
    endfunction

    // A missing operand is reported ahead of a term overrun; any cause other
    // than ERR_NONE raises the sticky protocol flag.
    function automatic err_cause_e errCause(input logic xValid, input logic wValid,
                                            input logic termFull);
        if (!xValid) begin
            return ERR_NO_X;
        end else if (!wValid) begin
            return ERR_NO_W;
        end else if (termFull) begin
            return ERR_TERM_OVR;
        end
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/mac_datapath_if.sv
// -----------------------------------------------------------------------------
// mac_datapath_if
// Bundles the controller strobes, operands, read port and status flags of the
// MAC datapath.
//   master : controller / consumer side (drives strobes, operands, rd_addr)
//   slave  : datapath side (drives rd_data, res_valid, res_idx, run_done,
//            proto_err, ovf)
// Parameters N (data width) and Q (result bank depth) must match the datapath.
// -----------------------------------------------------------------------------
interface mac_datapath_if
    import mac_datapath_pkg::*;
#(
    parameter int N = 8,
    parameter int Q = 3
);
    localparam int AW = ptrWidth(Q);

    logic          rst_dp;
    logic          write_x;
    logic          write_w;
    logic [N-1:0]  x;
    logic [N-1:0]  weight;
    logic          acc_write;
    logic          res_write;
    logic          clear_acc;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  rd_data;
    logic          res_valid;
    logic [AW-1:0] res_idx;
    logic          run_done;
    logic          proto_err;
    logic          ovf;

    modport master (
        output rst_dp, write_x, write_w, x, weight, acc_write, res_write,
               clear_acc, done, rd_addr,
        input  rd_data, res_valid, res_idx, run_done, proto_err, ovf
    );

    modport slave (
        input  rst_dp, write_x, write_w, x, weight, acc_write, res_write,
               clear_acc, done, rd_addr,
        output rd_data, res_valid, res_idx, run_done, proto_err, ovf
    );

endinterface

// File: rtl/mac_result_bank.sv
// -----------------------------------------------------------------------------
// mac_result_bank
// Q x N result storage with a synchronous write port and a registered read.
//   clk        : clock
//   rst        : synchronous active-high reset, zeroes contents and rd_data_o
//   rd_clr_i   : zeroes rd_data_o only, contents are kept
//   wr_en_i    : write wr_data_i at wr_addr_i
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_addr_i  : read address (out-of-range reads return 0)
//   rd_data_o  : read data, one cycle after rd_addr_i
// -----------------------------------------------------------------------------
module mac_result_bank #(
    parameter int N  = 8,
    parameter int Q  = 3,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_clr_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [N-1:0]  wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [N-1:0]  rd_data_o
);

    logic [N-1:0] mem_q [Q];
    logic [N-1:0] rdData_q;

    logic wrInRange;
    logic rdInRange;

    assign wrInRange = ({1'b0, wr_addr_i} < (AW + 1)'(Q));
    assign rdInRange = ({1'b0, rd_addr_i} < (AW + 1)'(Q));

    // Storage array. Only the hard reset wipes it so results survive a soft
    // clear from the controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Q; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i && wrInRange) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read. A read of the slot being written in the same cycle
    // sees the old contents because the array updates on the same edge.
    always_ff @(posedge clk) begin
        if (rst || rd_clr_i) begin
            rdData_q <= '0;
        end else begin
            rdData_q <= rdInRange ? mem_q[rd_addr_i] : '0;
        end
    end

    assign rd_data_o = rdData_q;

endmodule

// File: rtl/mac_datapath.sv
// -----------------------------------------------------------------------------
// mac_datapath
// Multiply-accumulate responder for the dot-product controller. Operand and
// weight registers feed a signed multiplier; products accumulate until the
// controller stores the scaled sum into the result bank.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (also zeroes the result bank)
//   bus  : mac_datapath_if.slave - strobes, operands, rst_dp soft clear,
//          rd_addr/rd_data read port, res_valid/res_idx, run_done,
//          proto_err, ovf
// Build option: define MAC_SAT_EN to saturate stored results and drive ovf;
// without it stored results wrap and ovf is tied 0.
// -----------------------------------------------------------------------------
module mac_datapath
    import mac_datapath_pkg::*;
#(
    parameter int N = 8,
    parameter int d = 4,
    parameter int Q = 3,
    parameter int F = 0
) (
    input  logic           clk,
    input  logic           rst,
    mac_datapath_if.slave  bus
);

    localparam int A  = accWidth(N, d);
    localparam int PW = ptrWidth(Q);
    localparam int TW = termWidth(d);

    logic signed [N-1:0]   xReg_q,    xReg_d;
    logic signed [N-1:0]   wReg_q,    wReg_d;
    logic                  xValid_q,  xValid_d;
    logic                  wValid_q,  wValid_d;
    logic signed [A-1:0]   acc_q,     acc_d;
    logic [TW-1:0]         term_q,    term_d;
    logic [PW-1:0]         qPtr_q,    qPtr_d;
    logic                  resValid_q, resValid_d;
    logic [PW-1:0]         resIdx_q,  resIdx_d;
    logic                  runDone_q, runDone_d;
    logic                  protoErr_q, protoErr_d;

    logic signed [2*N-1:0] product;
    logic signed [A-1:0]   prodExt;
    logic                  termFull;
    err_cause_e            cause;
    logic [N-1:0]          storeData;

    // Full-width signed product of the register outputs, so a same-cycle
    // operand load never reaches this cycle's product.
    assign product  = (2 * N)'(xReg_q) * (2 * N)'(wReg_q);
    assign prodExt  = A'(product);

    // A clear in the same cycle restarts the count, so it cannot overrun.
    assign termFull = (term_q == TW'(d)) && !bus.clear_acc;
    assign cause    = errCause(xValid_q, wValid_q, termFull);

    // Stored value is always derived from the pre-edge accumulator, which is
    // what gives res_write its "excludes this cycle's product" behaviour.
`ifdef MAC_SAT_EN
    assign storeData = N'(scaleSat(64'(acc_q), N, F));
`else
    assign storeData = N'(acc_q >>> F);
`endif

    // Next-state logic. Clear takes precedence over accumulate, but a
    // simultaneous acc_write seeds the fresh sum with its product. Operand
    // write strobes are applied last so a load alongside acc_write leaves
    // that register freshly valid.
    always_comb begin
        xReg_d     = xReg_q;
        wReg_d     = wReg_q;
        xValid_d   = xValid_q;
        wValid_d   = wValid_q;
        acc_d      = acc_q;
        term_d     = term_q;
        qPtr_d     = qPtr_q;
        resValid_d = bus.res_write;
        resIdx_d   = resIdx_q;
        runDone_d  = runDone_q | bus.done;
        protoErr_d = protoErr_q;

        if (bus.clear_acc) begin
            acc_d    = bus.acc_write ? prodExt : '0;
            term_d   = bus.acc_write ? TW'(1) : '0;
            xValid_d = 1'b0;
            wValid_d = 1'b0;
        end else if (bus.acc_write) begin
            acc_d = acc_q + prodExt;
            if (!termFull) begin
                term_d = term_q + TW'(1);
            end
        end

        if (bus.acc_write) begin
            xValid_d = 1'b0;
            wValid_d = 1'b0;
            if (cause != ERR_NONE) begin
                protoErr_d = 1'b1;
            end
        end

        if (bus.write_x) begin
            xReg_d   = bus.x;
            xValid_d = 1'b1;
        end
        if (bus.write_w) begin
            wReg_d   = bus.weight;
            wValid_d = 1'b1;
        end

        if (bus.res_write) begin
            resIdx_d = qPtr_q;
            qPtr_d   = (qPtr_q == PW'(Q - 1)) ? '0 : qPtr_q + PW'(1);
        end
    end

    // State registers. The soft clear behaves like reset here; only the
    // result bank distinguishes the two.
    always_ff @(posedge clk) begin
        if (rst || bus.rst_dp) begin
            xReg_q     <= '0;
            wReg_q     <= '0;
            xValid_q   <= 1'b0;
            wValid_q   <= 1'b0;
            acc_q      <= '0;
            term_q     <= '0;
            qPtr_q     <= '0;
            resValid_q <= 1'b0;
            resIdx_q   <= '0;
            runDone_q  <= 1'b0;
            protoErr_q <= 1'b0;
        end else begin
            xReg_q     <= xReg_d;
            wReg_q     <= wReg_d;
            xValid_q   <= xValid_d;
            wValid_q   <= wValid_d;
            acc_q      <= acc_d;
            term_q     <= term_d;
            qPtr_q     <= qPtr_d;
            resValid_q <= resValid_d;
            resIdx_q   <= resIdx_d;
            runDone_q  <= runDone_d;
            protoErr_q <= protoErr_d;
        end
    end

`ifdef MAC_SAT_EN
    logic ovf_q;
    logic ovf_d;

    assign ovf_d = ovf_q | (bus.res_write & scaleClamps(64'(acc_q), N, F));

    // Sticky overflow, set by any store that had to clamp.
    always_ff @(posedge clk) begin
        if (rst || bus.rst_dp) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    // A soft clear in the same cycle as a store drops the store so the bank
    // never sees a half-cleared datapath.
    mac_result_bank #(
        .N  (N),
        .Q  (Q),
        .AW (PW)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .rd_clr_i  (bus.rst_dp),
        .wr_en_i   (bus.res_write && !bus.rst_dp),
        .wr_addr_i (qPtr_q),
        .wr_data_i (storeData),
        .rd_addr_i (bus.rd_addr),
        .rd_data_o (bus.rd_data)
    );

    assign bus.res_valid = resValid_q;
    assign bus.res_idx   = resIdx_q;
    assign bus.run_done  = runDone_q;
    assign bus.proto_err = protoErr_q;

endmodule

// File: tb/tb_mac_datapath.sv
// -----------------------------------------------------------------------------
// tb_mac_datapath
// Directed self-checking bench for mac_datapath at N=8, d=4, Q=3, F=0.
// Expectations for the extreme-product case follow MAC_SAT_EN.
// -----------------------------------------------------------------------------
module tb_mac_datapath;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mac_datapath_if #(.N(8), .Q(3)) bus ();

    mac_datapath #(
        .N (8),
        .d (4),
        .Q (3),
        .F (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Return all strobes to their idle level.
    task automatic idle();
        bus.rst_dp    = 1'b0;
        bus.write_x   = 1'b0;
        bus.write_w   = 1'b0;
        bus.acc_write = 1'b0;
        bus.res_write = 1'b0;
        bus.clear_acc = 1'b0;
        bus.done      = 1'b0;
    endtask

    // Advance one clock and land 1 ns after the edge for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hardReset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Load one operand pair, then accumulate it on the following cycle.
    task automatic loadTerm(input logic [7:0] xv, input logic [7:0] wv);
        bus.x       = xv;
        bus.weight  = wv;
        bus.write_x = 1'b1;
        bus.write_w = 1'b1;
        tick();
        idle();
        bus.acc_write = 1'b1;
        tick();
        idle();
    endtask

    task automatic storeResult();
        bus.res_write = 1'b1;
        tick();
        idle();
    endtask

    task automatic clearAcc();
        bus.clear_acc = 1'b1;
        tick();
        idle();
    endtask

    task automatic readAddr(input logic [1:0] a);
        bus.rd_addr = a;
        tick();
    endtask

    task automatic test_reset();
        bus.x = '0;
        bus.weight = '0;
        bus.rd_addr = '0;
        hardReset();
        checks++;
        if (bus.rd_data !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_rd_data got=%0d exp=0", bus.rd_data);
        end
        checks++;
        if (bus.res_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_res_valid got=%b exp=0", bus.res_valid);
        end
        checks++;
        if (bus.run_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_run_done got=%b exp=0", bus.run_done);
        end
        checks++;
        if (bus.proto_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_proto_err got=%b exp=0", bus.proto_err);
        end
        checks++;
        if (bus.ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ovf got=%b exp=0", bus.ovf);
        end
    endtask

    // 1*5 + 2*6 + 3*7 + 4*8 = 70 stored at idx 0.
    task automatic test_basic_dot();
        loadTerm(8'd1, 8'd5);
        loadTerm(8'd2, 8'd6);
        loadTerm(8'd3, 8'd7);
        loadTerm(8'd4, 8'd8);
        storeResult();
        checks++;
        if (bus.res_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_res_valid got=%b exp=1", bus.res_valid);
        end
        checks++;
        if (bus.res_idx !== 2'd0) begin
            failures++;
            $display("[TB] FAIL basic_res_idx got=%0d exp=0", bus.res_idx);
        end
        tick();
        checks++;
        if (bus.res_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_res_valid_pulse got=%b exp=0", bus.res_valid);
        end
        readAddr(2'd0);
        checks++;
        if (bus.rd_data !== 8'd70) begin
            failures++;
            $display("[TB] FAIL basic_rd0 got=%0d exp=70", bus.rd_data);
        end
        checks++;
        if (bus.proto_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_proto_err got=%b exp=0", bus.proto_err);
        end
    endtask

    // Two terms, done, then rst_dp: flags drop, bank keeps 70, pointer and
    // accumulator restart from zero.
    task automatic test_soft_clear();
        clearAcc();
        loadTerm(8'd3, 8'd3);
        loadTerm(8'd4, 8'd4);
        bus.done = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.run_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL soft_run_done_set got=%b exp=1", bus.run_done);
        end
        bus.rd_addr = 2'd0;
        bus.rst_dp  = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.rd_data !== 8'd0) begin
            failures++;
            $display("[TB] FAIL soft_rd_data_cleared got=%0d exp=0", bus.rd_data);
        end
        checks++;
        if (bus.run_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL soft_run_done_clr got=%b exp=0", bus.run_done);
        end
        readAddr(2'd0);
        checks++;
        if (bus.rd_data !== 8'd70) begin
            failures++;
            $display("[TB] FAIL soft_bank_kept got=%0d exp=70", bus.rd_data);
        end
        // Valid flags were cleared, so a bare acc_write is a violation; the
        // registers are zero so it adds nothing.
        bus.acc_write = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.proto_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL soft_flags_cleared got=%b exp=1", bus.proto_err);
        end
        storeResult();
        checks++;
        if (bus.res_idx !== 2'd0) begin
            failures++;
            $display("[TB] FAIL soft_ptr_zero got=%0d exp=0", bus.res_idx);
        end
        readAddr(2'd0);
        checks++;
        if (bus.rd_data !== 8'd0) begin
            failures++;
            $display("[TB] FAIL soft_acc_zero got=%0d exp=0", bus.rd_data);
        end
    endtask

    // run_done is sticky across idle cycles and only rst drops it.
    task automatic test_run_done();
        hardReset();
        bus.done = 1'b1;
        tick();
        idle();
        tick();
        tick();
        tick();
        checks++;
        if (bus.run_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL run_done_sticky got=%b exp=1", bus.run_done);
        end
        hardReset();
        checks++;
        if (bus.run_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL run_done_rst got=%b exp=0", bus.run_done);
        end
    endtask

    // Four runs: 70, 4, 27, -3; the fourth wraps to idx 0.
    task automatic test_wrap_ptr();
        hardReset();
        loadTerm(8'd1, 8'd5);
        loadTerm(8'd2, 8'd6);
        loadTerm(8'd3, 8'd7);
        loadTerm(8'd4, 8'd8);
        storeResult();
        clearAcc();
        for (int i = 0; i < 4; i++) begin
            loadTerm(8'd1, 8'd1);
        end
        storeResult();
        checks++;
        if (bus.res_idx !== 2'd1) begin
            failures++;
            $display("[TB] FAIL wrap_idx1 got=%0d exp=1", bus.res_idx);
        end
        clearAcc();
        loadTerm(8'd2, 8'd3);
        loadTerm(8'hFF, 8'd4);
        loadTerm(8'd0, 8'd0);
        loadTerm(8'd5, 8'd5);
        storeResult();
        checks++;
        if (bus.res_idx !== 2'd2) begin
            failures++;
            $display("[TB] FAIL wrap_idx2 got=%0d exp=2", bus.res_idx);
        end
        clearAcc();
        loadTerm(8'hFD, 8'd2);
        loadTerm(8'd1, 8'd1);
        loadTerm(8'd1, 8'd1);
        loadTerm(8'd1, 8'd1);
        bus.rd_addr = 2'd0;
        storeResult();
        checks++;
        if (bus.res_idx !== 2'd0) begin
            failures++;
            $display("[TB] FAIL wrap_idx0 got=%0d exp=0", bus.res_idx);
        end
        checks++;
        if (bus.rd_data !== 8'd70) begin
            failures++;
            $display("[TB] FAIL wrap_read_old got=%0d exp=70", bus.rd_data);
        end
        readAddr(2'd0);
        checks++;
        if (bus.rd_data !== 8'hFD) begin
            failures++;
            $display("[TB] FAIL wrap_rd0 got=%0d exp=253", bus.rd_data);
        end
        readAddr(2'd1);
        checks++;
        if (bus.rd_data !== 8'd4) begin
            failures++;
            $display("[TB] FAIL wrap_rd1 got=%0d exp=4", bus.rd_data);
        end
        readAddr(2'd2);
        checks++;
        if (bus.rd_data !== 8'd27) begin
            failures++;
            $display("[TB] FAIL wrap_rd2 got=%0d exp=27", bus.rd_data);
        end
        checks++;
        if (bus.proto_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wrap_proto_err got=%b exp=0", bus.proto_err);
        end
    endtask

    // Extreme products: 16384, 16129 and -16256.
    task automatic test_extremes();
        logic [7:0] expA;
        logic [7:0] expB;
        logic [7:0] expC;
        logic       expOvf;
`ifdef MAC_SAT_EN
        expA = 8'd127;
        expB = 8'd127;
        expC = 8'h80;
        expOvf = 1'b1;
`else
        expA = 8'd0;
        expB = 8'd1;
        expC = 8'h80;
        expOvf = 1'b0;
`endif
        hardReset();
        loadTerm(8'h80, 8'h80);
        storeResult();
        tick();
        checks++;
        if (bus.ovf !== expOvf) begin
            failures++;
            $display("[TB] FAIL ext_ovf got=%b exp=%b", bus.ovf, expOvf);
        end
        clearAcc();
        loadTerm(8'd127, 8'd127);
        storeResult();
        clearAcc();
        loadTerm(8'h80, 8'd127);
        storeResult();
        readAddr(2'd0);
        checks++;
        if (bus.rd_data !== expA) begin
            failures++;
            $display("[TB] FAIL ext_neg_neg got=%0d exp=%0d", bus.rd_data, expA);
        end
        readAddr(2'd1);
        checks++;
        if (bus.rd_data !== expB) begin
            failures++;
            $display("[TB] FAIL ext_pos_pos got=%0d exp=%0d", bus.rd_data, expB);
        end
        readAddr(2'd2);
        checks++;
        if (bus.rd_data !== expC) begin
            failures++;
            $display("[TB] FAIL ext_neg_pos got=%0d exp=%0d", bus.rd_data, expC);
        end
    endtask

    // Missing operands and a fifth term all raise proto_err; the fifth
    // term is still accumulated (4*1 + 2*2 = 8).
    task automatic test_proto_err();
        hardReset();
        bus.x = 8'd1;
        bus.write_x = 1'b1;
        tick();
        idle();
        bus.acc_write = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.proto_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL proto_no_w got=%b exp=1", bus.proto_err);
        end
        hardReset();
        checks++;
        if (bus.proto_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL proto_rst got=%b exp=0", bus.proto_err);
        end
        bus.weight = 8'd1;
        bus.write_w = 1'b1;
        tick();
        idle();
        bus.acc_write = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.proto_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL proto_no_x got=%b exp=1", bus.proto_err);
        end
        hardReset();
        for (int i = 0; i < 4; i++) begin
            loadTerm(8'd1, 8'd1);
        end
        checks++;
        if (bus.proto_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL proto_four_terms got=%b exp=0", bus.proto_err);
        end
        loadTerm(8'd2, 8'd2);
        checks++;
        if (bus.proto_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL proto_fifth_term got=%b exp=1", bus.proto_err);
        end
        storeResult();
        readAddr(2'd0);
        checks++;
        if (bus.rd_data !== 8'd8) begin
            failures++;
            $display("[TB] FAIL proto_fifth_acc got=%0d exp=8", bus.rd_data);
        end
    endtask

    // clear_acc+acc_write seeds acc=-6 with count 1; res_write+acc_write
    // stores -6 then adds 5. Two more terms reach count 4 with no error,
    // a further one overruns; final sum -1+1+1+1 = 2.
    task automatic test_same_cycle();
        hardReset();
        bus.x = 8'd3;
        bus.weight = 8'hFE;
        bus.write_x = 1'b1;
        bus.write_w = 1'b1;
        tick();
        idle();
        bus.clear_acc = 1'b1;
        bus.acc_write = 1'b1;
        tick();
        idle();
        bus.x = 8'd5;
        bus.weight = 8'd1;
        bus.write_x = 1'b1;
        bus.write_w = 1'b1;
        tick();
        idle();
        bus.res_write = 1'b1;
        bus.acc_write = 1'b1;
        tick();
        idle();
        loadTerm(8'd1, 8'd1);
        loadTerm(8'd1, 8'd1);
        checks++;
        if (bus.proto_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL same_cnt_four got=%b exp=0", bus.proto_err);
        end
        loadTerm(8'd1, 8'd1);
        checks++;
        if (bus.proto_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL same_cnt_over got=%b exp=1", bus.proto_err);
        end
        storeResult();
        readAddr(2'd0);
        checks++;
        if (bus.rd_data !== 8'hFA) begin
            failures++;
            $display("[TB] FAIL same_clear_acc got=%0d exp=250", bus.rd_data);
        end
        readAddr(2'd1);
        checks++;
        if (bus.rd_data !== 8'd2) begin
            failures++;
            $display("[TB] FAIL same_res_acc got=%0d exp=2", bus.rd_data);
        end
    endtask

    // write_x alongside acc_write: product uses old x (2*3), new x=10 stays
    // valid for the next term (10*1); total 16 with no violation.
    task automatic test_back_to_back();
        hardReset();
        bus.x = 8'd2;
        bus.weight = 8'd3;
        bus.write_x = 1'b1;
        bus.write_w = 1'b1;
        tick();
        idle();
        bus.x = 8'd10;
        bus.write_x = 1'b1;
        bus.acc_write = 1'b1;
        tick();
        idle();
        bus.weight = 8'd1;
        bus.write_w = 1'b1;
        tick();
        idle();
        bus.acc_write = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.proto_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_proto_err got=%b exp=0", bus.proto_err);
        end
        storeResult();
        readAddr(2'd0);
        checks++;
        if (bus.rd_data !== 8'd16) begin
            failures++;
            $display("[TB] FAIL b2b_sum got=%0d exp=16", bus.rd_data);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_basic_dot();
        test_soft_clear();
        test_run_done();
        test_wrap_ptr();
        test_extremes();
        test_proto_err();
        test_same_cycle();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
